mcp3008_sampler: RTL and testbench
==================================

// Module: mcp3008_sampler
// PURPOSE
//  Free-running SPI master for the MCP3008 10-bit ADC on the Pmod_ADC board.
//  Periodically runs one 17-SCLK conversion frame and returns the 10-bit result
//  with a one-cycle valid strobe.
//  Sits upstream of the FFT input (xn_re) and the 7-seg display path, replacing ad-hoc counter-driven ADC sequencing.
// PARAMETERS
//  CLK_DIV        27     clk cycles per SCLK half-period (27 MHz clk -> 500 kHz SCLK); legal >= 1
//  CS_HIGH_CYCLES 8      minimum clk cycles CS held high between frames (tCSH); legal >= 1
//  SAMPLE_PERIOD  2700   clk cycles from one frame start to the next (100 us); legal >= 1
// PORTS
//  clk           in   1   system clock
//  rst_n         in   1   asynchronous, active-low reset
//  enable        in   1   1 = free-run conversions; 0 = finish current frame, then idle
//  channel       in   3   ADC channel select (D2..D0), latched at frame start
//  single_ended  in   1   1 = single-ended, 0 = differential (SGL/DIFF bit), latched at frame start
//  AD_CLK        out  1   SPI SCLK to ADC, mode 0 (idle low)
//  CS            out  1   ADC chip select, active low
//  DIN           out  1   command bits to ADC
//  DOUT          in   1   result bits from ADC
//  sample_data   out  10  last completed conversion, B9 = MSB
//  sample_valid  out  1   one-clk pulse when sample_data updates
//  null_err      out  1   sticky: a null bit read as 1 (framing fault)
//  busy          out  1   high from CS fall until CS rises
// BEHAVIOUR
//  - Reset (async, rst_n = 0): AD_CLK = 0, CS = 1, DIN = 0, sample_data = 0, sample_valid = 0, null_err = 0, busy = 0.
//    Also state IDLE, all counters 0. Reset mid-frame aborts at once: CS high, no valid pulse.
//  - FSM: IDLE -> SHIFT -> CSHIGH -> (WAIT | SHIFT | IDLE).
//    - IDLE: when enable = 1, start a frame on the next clk edge.
//    - Frame start (cycle T0): CS <= 0, busy <= 1; latch channel and single_ended; DIN <= 1 (start bit); SCLK low.
//    - SHIFT: div_cnt counts 0..CLK_DIV-1; each wrap toggles AD_CLK.
//      Rising edge k (k = 1..17) occurs at T0 + (2k-1)*CLK_DIV.
//    - DIN sequence: DIN is updated on the falling edge preceding rising edge k.
//      Rising edges 1..5 carry start=1, SGL, D2, D1, D0. Rising edges 6..17 carry DIN = 0.
//    - DOUT is sampled on rising edges only. Edge 6 is the sample period (ignored).
//      Edge 7 is the null bit; if it reads 1, set null_err (cleared only by reset).
//      Edges 8..17 shift in B9..B0 (MSB first) into a shadow register.
//    - After the 17th falling edge (T0 + 34*CLK_DIV): CS <= 1, busy <= 0, AD_CLK stays 0.
//      sample_data <= shadow and sample_valid = 1 for exactly that one cycle. Enter CSHIGH.
//    - CSHIGH: hold CS high for CS_HIGH_CYCLES clk cycles.
//      If enable = 0, go to IDLE. Otherwise, if the period timer has expired, go to SHIFT; else go to WAIT.
//    - WAIT: start the next frame when the period timer reaches SAMPLE_PERIOD-1 measured from T0.
//      If enable drops, go to IDLE.
//  - Period timer: restarts at each frame start and saturates once expired.
//    Effective period = max(SAMPLE_PERIOD, 34*CLK_DIV + CS_HIGH_CYCLES).
//  - enable dropping mid-frame never truncates the frame. channel changes mid-frame do not affect it.
//  - sample_data holds its value between valid pulses. No back-pressure: the consumer must take data on sample_valid.
// TESTING
//  - Reset: hold rst_n = 0 -> CS = 1, AD_CLK = 0, DIN = 0, sample_valid = 0, busy = 0.
//    Assert rst_n = 0 mid-frame -> CS = 1 in the same cycle and no valid pulse.
//  - CLK_DIV = 2, channel = 5, single_ended = 1, ADC model returns 10'h2A5.
//    Expect DIN on rising edges 1..5 = 1,1,1,0,1; 17 rising edges; CS rises at T0+68.
//    Expect sample_data = 10'h2A5 with sample_valid high for 1 cycle at T0+68.
//  - SAMPLE_PERIOD = 100, CLK_DIV = 2, CS_HIGH_CYCLES = 8 -> CS falls at T0, T0+100, T0+200, ...
//    With SAMPLE_PERIOD = 10 -> frame starts spaced exactly 76 cycles apart.
//  - Differential, channel = 3, ADC returns 10'h3FF then 10'h000.
//    Expect DIN edges 1..5 = 1,0,0,1,1 and two valid pulses carrying 10'h3FF then 10'h000.
//  - ADC model drives the null bit = 1 -> null_err = 1 after that frame.
//    null_err stays 1 across later good frames until reset.
//  - enable dropped at T0+10 -> current frame completes with a valid pulse.
//    CS then stays 1 and no further frames start. Re-raising enable -> a new frame starts the next cycle.

Source files
------------

// File: rtl/mcp3008_sampler.sv
// Free-running SPI master for the MCP3008 ADC: one 17-SCLK frame per sample period,
// result presented on sample_data with a single-cycle sample_valid strobe.
module mcp3008_sampler #(
    parameter int CLK_DIV        = 27,
    parameter int CS_HIGH_CYCLES = 8,
    parameter int SAMPLE_PERIOD  = 2700
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [2:0] channel,
    input  logic       single_ended,
    output logic       AD_CLK,
    output logic       CS,
    output logic       DIN,
    input  logic       DOUT,
    output logic [9:0] sample_data,
    output logic       sample_valid,
    output logic       null_err,
    output logic       busy
);

    localparam int DIV_W = (CLK_DIV > 1)        ? $clog2(CLK_DIV)        : 1;
    localparam int CSH_W = (CS_HIGH_CYCLES > 1) ? $clog2(CS_HIGH_CYCLES) : 1;
    localparam int PER_W = (SAMPLE_PERIOD > 1)  ? $clog2(SAMPLE_PERIOD)  : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CSH_W-1:0] CSH_LAST = CSH_W'(CS_HIGH_CYCLES - 1);
    localparam logic [PER_W-1:0] PER_LAST = PER_W'(SAMPLE_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        CSHIGH,
        WAIT
    } state_t;

    state_t           state;
    logic [DIV_W-1:0] div_cnt;
    logic [5:0]       tog_cnt;
    logic [CSH_W-1:0] cs_cnt;
    logic [PER_W-1:0] period_cnt;
    logic [3:0]       cmd_sr;
    logic [9:0]       shadow;
    logic             period_done;
    logic             cs_done;
    logic             start_frame;

    assign period_done = (period_cnt == PER_LAST);
    assign cs_done     = (cs_cnt == CSH_LAST);

    // A frame can be launched from three states; decode it once so the
    // start actions live in a single place below.
    always_comb begin
        start_frame = 1'b0;
        case (state)
            IDLE:    start_frame = enable;
            CSHIGH:  start_frame = cs_done && enable && period_done;
            WAIT:    start_frame = enable && period_done;
            default: start_frame = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            div_cnt      <= '0;
            tog_cnt      <= '0;
            cs_cnt       <= '0;
            period_cnt   <= '0;
            cmd_sr       <= '0;
            shadow       <= '0;
            AD_CLK       <= 1'b0;
            CS           <= 1'b1;
            DIN          <= 1'b0;
            sample_data  <= '0;
            sample_valid <= 1'b0;
            null_err     <= 1'b0;
            busy         <= 1'b0;
        end else begin
            sample_valid <= 1'b0;

            // Period timer is measured from frame start and parks at its last count.
            if (start_frame)
                period_cnt <= '0;
            else if (!period_done)
                period_cnt <= period_cnt + PER_W'(1);

            if (start_frame) begin
                state   <= SHIFT;
                CS      <= 1'b0;
                busy    <= 1'b1;
                DIN     <= 1'b1;
                cmd_sr  <= {single_ended, channel};
                div_cnt <= '0;
                tog_cnt <= '0;
                AD_CLK  <= 1'b0;
            end else begin
                case (state)
                    SHIFT: begin
                        if (div_cnt == DIV_LAST) begin
                            div_cnt <= '0;
                            if (!AD_CLK) begin
                                // Rising edge k sees tog_cnt = 2(k-1): edge 7 is the null bit, 8..17 carry B9..B0.
                                AD_CLK  <= 1'b1;
                                tog_cnt <= tog_cnt + 6'd1;
                                if (tog_cnt == 6'd12 && DOUT)
                                    null_err <= 1'b1;
                                if (tog_cnt >= 6'd14)
                                    shadow <= {shadow[8:0], DOUT};
                            end else if (tog_cnt == 6'd33) begin
                                AD_CLK       <= 1'b0;
                                CS           <= 1'b1;
                                busy         <= 1'b0;
                                DIN          <= 1'b0;
                                sample_data  <= shadow;
                                sample_valid <= 1'b1;
                                tog_cnt      <= '0;
                                cs_cnt       <= '0;
                                state        <= CSHIGH;
                            end else begin
                                AD_CLK  <= 1'b0;
                                tog_cnt <= tog_cnt + 6'd1;
                                DIN     <= cmd_sr[3];
                                cmd_sr  <= {cmd_sr[2:0], 1'b0};
                            end
                        end else begin
                            div_cnt <= div_cnt + DIV_W'(1);
                        end
                    end
                    CSHIGH: begin
                        if (cs_done) begin
                            if (!enable)
                                state <= IDLE;
                            else
                                state <= WAIT;
                        end else begin
                            cs_cnt <= cs_cnt + CSH_W'(1);
                        end
                    end
                    WAIT: begin
                        if (!enable)
                            state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mcp3008_sampler.sv
// Directed bench for mcp3008_sampler with a behavioural MCP3008 model driving DOUT.
module tb_mcp3008_sampler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [2:0] channel;
    logic       single_ended;
    logic       ad_clk;
    logic       cs;
    logic       din;
    logic       dout;
    logic [9:0] sample_data;
    logic       sample_valid;
    logic       null_err;
    logic       busy;

    logic       enable2;
    logic       ad_clk2;
    logic       cs2;
    logic       din2;
    logic       dout2 = 1'b0;
    logic [9:0] sample_data2;
    logic       sample_valid2;
    logic       null_err2;
    logic       busy2;

    mcp3008_sampler #(.CLK_DIV(2), .CS_HIGH_CYCLES(8), .SAMPLE_PERIOD(100)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .channel(channel),
        .single_ended(single_ended), .AD_CLK(ad_clk), .CS(cs), .DIN(din), .DOUT(dout),
        .sample_data(sample_data), .sample_valid(sample_valid), .null_err(null_err), .busy(busy)
    );

    mcp3008_sampler #(.CLK_DIV(2), .CS_HIGH_CYCLES(8), .SAMPLE_PERIOD(10)) dut2 (
        .clk(clk), .rst_n(rst_n), .enable(enable2), .channel(channel),
        .single_ended(single_ended), .AD_CLK(ad_clk2), .CS(cs2), .DIN(din2), .DOUT(dout2),
        .sample_data(sample_data2), .sample_valid(sample_valid2), .null_err(null_err2), .busy(busy2)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc++;

    // ADC model: counts SCLK rising edges per frame and presents the next bit on each falling edge.
    logic [9:0] adc_val;
    logic       adc_null;
    int         rise_cnt = 0;
    logic       din_rec [1:17];

    initial dout = 1'b0;

    always @(negedge cs) begin
        rise_cnt = 0;
        dout     = 1'b0;
    end

    always @(posedge ad_clk) begin
        rise_cnt++;
        if (rise_cnt >= 1 && rise_cnt <= 17)
            din_rec[rise_cnt] = din;
    end

    always @(negedge ad_clk) begin : adc_drive
        int nb;
        if (cs === 1'b0) begin
            nb = rise_cnt + 1;
            if (nb == 7)
                dout = adc_null;
            else if (nb >= 8 && nb <= 17)
                dout = adc_val[17 - nb];
            else
                dout = 1'b0;
        end
    end

    int         t0 = 0;
    int         starts = 0;
    int         valid_cnt = 0;
    int         valid_cyc = 0;
    logic [9:0] valid_data = '0;
    logic       cs_prev = 1'b1;
    int         starts2 = 0;
    int         t0s2 [3];
    logic       cs2_prev = 1'b1;

    always @(negedge clk) begin
        if (cs_prev === 1'b1 && cs === 1'b0) begin
            t0 = cyc;
            starts++;
        end
        cs_prev = cs;
        if (sample_valid === 1'b1) begin
            valid_cyc  = cyc;
            valid_data = sample_data;
            valid_cnt++;
        end
        if (cs2_prev === 1'b1 && cs2 === 1'b0) begin
            if (starts2 < 3)
                t0s2[starts2] = cyc;
            starts2++;
        end
        cs2_prev = cs2;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] ch, input logic sgl, input logic [9:0] val, input logic nul);
        channel      = ch;
        single_ended = sgl;
        adc_val      = val;
        adc_null     = nul;
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic waitValid(input string tag, input int limit);
        int v0;
        int n;
        v0 = valid_cnt;
        n  = 0;
        while (valid_cnt == v0 && n < limit) begin
            tick();
            n++;
        end
        checkOutput(tag, 32'(valid_cnt != v0), 32'd1);
    endtask

    task automatic waitStart(input string tag, input int limit);
        int s0;
        int n;
        s0 = starts;
        n  = 0;
        while (starts == s0 && n < limit) begin
            tick();
            n++;
        end
        checkOutput(tag, 32'(starts != s0), 32'd1);
    endtask

    function automatic logic [4:0] dinHead();
        return {din_rec[1], din_rec[2], din_rec[3], din_rec[4], din_rec[5]};
    endfunction

    function automatic logic dinTail();
        logic acc;
        acc = 1'b0;
        for (int i = 6; i <= 17; i++)
            acc = acc | din_rec[i];
        return acc;
    endfunction

    int prev;
    int s0;
    int n0;
    int v0;

    initial begin
        rst_n   = 1'b0;
        enable  = 1'b0;
        enable2 = 1'b0;
        applyStimulus(3'd5, 1'b1, 10'h2A5, 1'b0);
        repeat (3) tick();
        checkOutput("rst_cs",     32'(cs),           32'd1);
        checkOutput("rst_adclk",  32'(ad_clk),       32'd0);
        checkOutput("rst_din",    32'(din),          32'd0);
        checkOutput("rst_valid",  32'(sample_valid), 32'd0);
        checkOutput("rst_busy",   32'(busy),         32'd0);
        checkOutput("rst_data",   32'(sample_data),  32'd0);
        checkOutput("rst_nullerr", 32'(null_err),    32'd0);

        rst_n = 1'b1;
        tick();
        enable  = 1'b1;
        enable2 = 1'b1;

        // Single-ended channel 5, result 2A5
        waitStart("start1", 5);
        checkOutput("start1_cs",   32'(cs),   32'd0);
        checkOutput("start1_busy", 32'(busy), 32'd1);
        checkOutput("start1_din",  32'(din),  32'd1);
        waitValid("valid1", 200);
        checkOutput("f1_latency",  32'(valid_cyc - t0), 32'd68);
        checkOutput("f1_rises",    32'(rise_cnt),       32'd17);
        checkOutput("f1_din_head", 32'(dinHead()),      32'b11101);
        checkOutput("f1_din_tail", 32'(dinTail()),      32'd0);
        checkOutput("f1_data",     32'(valid_data),     32'h2A5);
        checkOutput("f1_cs_high",  32'(cs),             32'd1);
        checkOutput("f1_busy",     32'(busy),           32'd0);
        checkOutput("f1_adclk",    32'(ad_clk),         32'd0);
        tick();
        checkOutput("f1_valid_pulse", 32'(sample_valid), 32'd0);
        checkOutput("f1_data_hold",   32'(sample_data),  32'h2A5);

        // Differential channel 3, full-scale then zero, 100-cycle period
        prev = t0;
        applyStimulus(3'd3, 1'b0, 10'h3FF, 1'b0);
        waitValid("valid2", 200);
        checkOutput("f2_period",   32'(t0 - prev),  32'd100);
        checkOutput("f2_din_head", 32'(dinHead()),  32'b10011);
        checkOutput("f2_data",     32'(valid_data), 32'h3FF);
        prev = t0;
        applyStimulus(3'd3, 1'b0, 10'h000, 1'b0);
        waitValid("valid3", 200);
        checkOutput("f3_period",  32'(t0 - prev),  32'd100);
        checkOutput("f3_data",    32'(valid_data), 32'h000);
        checkOutput("f3_nullerr", 32'(null_err),   32'd0);

        // Short SAMPLE_PERIOD instance: spacing limited by frame + CS high time
        checkOutput("d2_starts", 32'(starts2 >= 3), 32'd1);
        checkOutput("d2_gap1",   32'(t0s2[1] - t0s2[0]), 32'd76);
        checkOutput("d2_gap2",   32'(t0s2[2] - t0s2[1]), 32'd76);

        // Null-bit fault is sticky across good frames
        applyStimulus(3'd1, 1'b1, 10'h155, 1'b1);
        waitValid("valid4", 200);
        checkOutput("f4_nullerr", 32'(null_err),   32'd1);
        checkOutput("f4_data",    32'(valid_data), 32'h155);
        applyStimulus(3'd1, 1'b1, 10'h0F0, 1'b0);
        waitValid("valid5", 200);
        checkOutput("f5_nullerr", 32'(null_err),   32'd1);
        checkOutput("f5_data",    32'(valid_data), 32'h0F0);

        // Dropping enable mid-frame lets the frame finish, then idles
        waitStart("start6", 200);
        repeat (9) tick();
        enable = 1'b0;
        waitValid("valid6", 200);
        checkOutput("f6_latency", 32'(valid_cyc - t0), 32'd68);
        checkOutput("f6_data",    32'(valid_data),     32'h0F0);
        s0 = starts;
        repeat (150) tick();
        checkOutput("idle_no_start", 32'(starts), 32'(s0));
        checkOutput("idle_cs",       32'(cs),     32'd1);
        checkOutput("idle_busy",     32'(busy),   32'd0);
        n0 = cyc;
        enable = 1'b1;
        waitStart("restart", 5);
        checkOutput("restart_cycle", 32'(t0), 32'(n0 + 1));

        // Reset mid-frame aborts immediately with no valid pulse
        repeat (20) tick();
        checkOutput("mid_cs_low", 32'(cs), 32'd0);
        v0 = valid_cnt;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_cs",    32'(cs),     32'd1);
        checkOutput("abort_busy",  32'(busy),   32'd0);
        checkOutput("abort_adclk", 32'(ad_clk), 32'd0);
        repeat (100) tick();
        checkOutput("abort_no_valid", 32'(valid_cnt), 32'(v0));
        checkOutput("abort_cs_hold",  32'(cs),        32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
